psx_poll_scheduler: RTL

PSX_POLL_SCHEDULER -- requirements
Module: psx_poll_scheduler

---
 rtl/psx_poll_scheduler.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/psx_poll_scheduler.sv
// psx_poll_scheduler: periodic two-port PSX pad poll sequencer.
// Drives att_n and a byte engine, checks the pad reply, latches buttons.
module psx_poll_scheduler #(
   parameter int POLL_DIV    = 7000,
   parameter int ATT_DELAY   = 4,
   parameter int ACK_TIMEOUT = 64,
   parameter int GAP         = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   output logic        xfer_start,
   output logic [7:0]  xfer_tx,
   input  logic [7:0]  xfer_rx,
   input  logic        xfer_done,
   input  logic        xfer_ack,
   output logic [1:0]  att_n,
   output logic [15:0] buttons0,
   output logic [15:0] buttons1,
   output logic [1:0]  valid,
   output logic [1:0]  present,
   output logic        busy,
   output logic        err
);

   localparam int TW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
   localparam logic [TW-1:0] T_END   = TW'(POLL_DIV - 1);
   localparam logic [15:0]   ATT_END = 16'(ATT_DELAY - 1);
   localparam logic [15:0]   ACK_END = 16'(ACK_TIMEOUT - 1);
   localparam logic [15:0]   GAP_END = 16'(GAP - 1);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] ATT_SETUP = 3'd1;
   localparam logic [2:0] SEND      = 3'd2;
   localparam logic [2:0] WAIT_DONE = 3'd3;
   localparam logic [2:0] WAIT_ACK  = 3'd4;
   localparam logic [2:0] GAP_WAIT  = 3'd5;
   localparam logic [2:0] RELEASE   = 3'd6;

   logic [2:0]    state;
   logic [TW-1:0] timer;
   logic          pending;
   logic          port;
   logic [2:0]    idx;
   logic [15:0]   cnt;
   logic [7:0]    slot1;
   logic [7:0]    slot2;
   logic [7:0]    slot3;

   logic take;
   logic got_done;
   logic ack_ok;
   logic tmo;
   logic fin;
   logic fin_ok;

   always_comb begin
      take     = (state == IDLE) && pending;
      got_done = (state == WAIT_DONE) && xfer_done;
      ack_ok   = (got_done && (idx != 3'd4) && xfer_ack) ||
                 ((state == WAIT_ACK) && xfer_ack);
      tmo      = (state == WAIT_ACK) && !xfer_ack && (cnt == ACK_END);
      // slot4 is still on xfer_rx in the finishing cycle
      fin      = (got_done && (idx == 3'd4)) || tmo;
      fin_ok   = got_done && (idx == 3'd4) &&
                 (slot1 == 8'h41) && (slot2 == 8'h5A);
   end

   always_comb begin
      xfer_start = (state == SEND);
      xfer_tx    = 8'h00;
      if (xfer_start) begin
         case (idx)
            3'd0:    xfer_tx = 8'h01;
            3'd1:    xfer_tx = 8'h42;
            default: xfer_tx = 8'h00;
         endcase
      end
      busy = (state != IDLE);
   end

   // A wrap always wins over consumption so no round request is lost.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         timer   <= '0;
         pending <= 1'b0;
      end else if (!enable) begin
         timer   <= '0;
         pending <= 1'b0;
      end else begin
         if (timer == T_END) begin
            timer   <= '0;
            pending <= 1'b1;
         end else begin
            timer <= timer + TW'(1);
            if (take) pending <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         port     <= 1'b0;
         idx      <= 3'd0;
         cnt      <= 16'd0;
         att_n    <= 2'b11;
         slot1    <= 8'h00;
         slot2    <= 8'h00;
         slot3    <= 8'h00;
         buttons0 <= 16'hFFFF;
         buttons1 <= 16'hFFFF;
         valid    <= 2'b00;
         present  <= 2'b00;
         err      <= 1'b0;
      end else begin
         err <= 1'b0;
         if (ack_ok && (idx == 3'd0)) present[port] <= 1'b1;
         if (tmo && (idx == 3'd0))    present[port] <= 1'b0;
         if (fin) begin
            att_n[port] <= 1'b1;
            valid[port] <= fin_ok;
            err         <= !fin_ok;
            if (fin_ok && !port) buttons0 <= {xfer_rx, slot3};
            if (fin_ok && port)  buttons1 <= {xfer_rx, slot3};
         end
         case (state)
            IDLE: begin
               if (take) begin
                  state <= ATT_SETUP;
                  port  <= 1'b0;
                  idx   <= 3'd0;
                  cnt   <= 16'd0;
                  att_n <= 2'b10;
               end
            end
            ATT_SETUP: begin
               if (cnt == ATT_END) begin
                  state <= SEND;
                  idx   <= 3'd0;
                  cnt   <= 16'd0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            SEND: begin
               state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (xfer_done) begin
                  case (idx)
                     3'd1:    slot1 <= xfer_rx;
                     3'd2:    slot2 <= xfer_rx;
                     3'd3:    slot3 <= xfer_rx;
                     default: ;
                  endcase
                  cnt <= 16'd0;
                  if (idx == 3'd4)  state <= RELEASE;
                  else if (xfer_ack) state <= GAP_WAIT;
                  else               state <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (xfer_ack) begin
                  state <= GAP_WAIT;
                  cnt   <= 16'd0;
               end else if (tmo) begin
                  state <= RELEASE;
                  cnt   <= 16'd0;
               end else if (cnt != 16'hFFFF) begin
                  cnt <= cnt + 16'd1;
               end
            end
            GAP_WAIT: begin
               if (cnt == GAP_END) begin
                  state <= SEND;
                  cnt   <= 16'd0;
                  if (idx < 3'd4) idx <= idx + 3'd1;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            RELEASE: begin
               if (cnt == GAP_END) begin
                  cnt <= 16'd0;
                  idx <= 3'd0;
                  if (!port) begin
                     port  <= 1'b1;
                     att_n <= 2'b01;
                     state <= ATT_SETUP;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
